// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronizes, debounces and registers the four
// memory-game buttons, producing one tem_jogada pulse per accepted press.
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       multipla,
    output logic       db_tem_jogada,
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CONT_UM  = CW'(1);
    localparam logic [CW-1:0] CONT_FIM = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        CONTANDO    = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    // A pattern with two or more buttons down is a wrong play for the game.
    function automatic logic mais_de_um_bit(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return (n > 3'd1);
    endfunction

    logic [3:0]    sinc_meta_q;
    logic [3:0]    sinc_q;
    estado_t       estado_q,     estado_d;
    logic [3:0]    padrao_q,     padrao_d;
    logic [CW-1:0] cont_q,       cont_d;
    logic [3:0]    jogada_q,     jogada_d;
    logic          multipla_q,   multipla_d;
    logic          tem_jogada_q, tem_jogada_d;

    // Two-flop synchronizer bringing the asynchronous button levels into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_meta_q <= 4'b0000;
            sinc_q      <= 4'b0000;
        end else begin
            sinc_meta_q <= botoes;
            sinc_q      <= sinc_meta_q;
        end
    end

    // State, debounce counter, candidate pattern and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            padrao_q     <= 4'b0000;
            cont_q       <= '0;
            jogada_q     <= 4'b0000;
            multipla_q   <= 1'b0;
            tem_jogada_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            padrao_q     <= padrao_d;
            cont_q       <= cont_d;
            jogada_q     <= jogada_d;
            multipla_q   <= multipla_d;
            tem_jogada_q <= tem_jogada_d;
        end
    end

    // Debounce FSM: a press is accepted once the same nonzero pattern is seen
    // for DEBOUNCE_CYCLES edges; a new press needs an equally stable release.
    always_comb begin
        estado_d     = estado_q;
        padrao_d     = padrao_q;
        cont_d       = cont_q;
        jogada_d     = jogada_q;
        multipla_d   = multipla_q;
        tem_jogada_d = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (sinc_q != 4'b0000) begin
                    padrao_d = sinc_q;
                    cont_d   = CONT_UM;
                    estado_d = CONTANDO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            CONTANDO: begin
                if (sinc_q == 4'b0000) begin
                    estado_d = OCIOSO;
                end else if (sinc_q != padrao_q) begin
                    padrao_d = sinc_q;
                    cont_d   = CONT_UM;
                    estado_d = CONTANDO;
                end else if (cont_q == CONT_FIM) begin
                    estado_d = PRESSIONADO;
                    // With habilita low the press is swallowed silently.
                    if (habilita) begin
                        jogada_d     = padrao_q;
                        multipla_d   = mais_de_um_bit(padrao_q);
                        tem_jogada_d = 1'b1;
                    end else begin
                        tem_jogada_d = 1'b0;
                    end
                end else begin
                    cont_d = cont_q + CONT_UM;
                end
            end
            PRESSIONADO: begin
                // Pattern changes while held are deliberately ignored.
                if (sinc_q == 4'b0000) begin
                    cont_d   = CONT_UM;
                    estado_d = SOLTANDO;
                end else begin
                    estado_d = PRESSIONADO;
                end
            end
            SOLTANDO: begin
                if (sinc_q != 4'b0000) begin
                    estado_d = PRESSIONADO;
                end else if (cont_q == CONT_FIM) begin
                    estado_d = OCIOSO;
                end else begin
                    cont_d = cont_q + CONT_UM;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = '0;
                padrao_d = 4'b0000;
            end
        endcase
    end

    assign jogada        = jogada_q;
    assign multipla      = multipla_q;
    assign tem_jogada    = tem_jogada_q;
    assign db_tem_jogada = |sinc_q;
    assign db_estado     = {2'b00, estado_q};

endmodule
